// File: rtl/camera_capture_pkg.sv
// Shared types and defaults for the camera capture block.
// Optional generated-pixel mode is enabled by defining CAMERA_CAPTURE_TEST_PATTERN_EN.
package camera_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    FRAME = 2'd2,
    LINE  = 2'd3
  } state_t;

  localparam int ADDR_W       = 25;
  localparam int PIX_W        = 10;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef logic [ADDR_W-1:0] sdram_addr_t;

  localparam sdram_addr_t DEF_BUF0_BASE  = 25'd0;
  localparam sdram_addr_t DEF_BUF_STRIDE = 25'd524288;

  // Generated pixel: low five bits of the line index over low five bits of the column.
  function automatic logic [PIX_W-1:0] pattern_pixel(input logic [4:0] x5, input logic [4:0] y5);
    return {y5, x5};
  endfunction

endpackage

// File: rtl/camera_capture_sync_edge.sv
// Registers the camera framing strobes and pixel once, and derives edge strobes
// by comparing the registered value against its own previous value.
module camera_capture_sync_edge
  import camera_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [PIX_W-1:0] cam_data,
  output logic             href,
  output logic [PIX_W-1:0] data,
  output logic             vsync_rise,
  output logic             vsync_fall,
  output logic             href_rise,
  output logic             href_fall
);

  logic vsync;
  logic vsync_prev;
  logic href_prev;

  // Input sampling register and one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync      <= 1'b0;
      vsync_prev <= 1'b0;
      href       <= 1'b0;
      href_prev  <= 1'b0;
      data       <= 10'd0;
    end else begin
      vsync      <= cam_vsync;
      vsync_prev <= vsync;
      href       <= cam_href;
      href_prev  <= href;
      data       <= cam_data;
    end
  end

  assign vsync_rise = vsync & ~vsync_prev;
  assign vsync_fall = ~vsync & vsync_prev;
  assign href_rise  = href & ~href_prev;
  assign href_fall  = ~href & href_prev;

endmodule

// File: rtl/camera_capture.sv
// Frames and crops a camera pixel stream into ping-pong SDRAM frame buffers (port C).
// Define CAMERA_CAPTURE_TEST_PATTERN_EN to let test_pattern substitute generated pixels.
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int          H_ACTIVE   = DEF_H_ACTIVE,
  parameter int          V_ACTIVE   = DEF_V_ACTIVE,
  parameter sdram_addr_t BUF0_BASE  = DEF_BUF0_BASE,
  parameter sdram_addr_t BUF_STRIDE = DEF_BUF_STRIDE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture_en,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [PIX_W-1:0]  cam_data,
  input  logic              test_pattern,
  output logic              portC_write,
  output logic [ADDR_W-1:0] portC_addr,
  output logic [PIX_W-1:0]  portC_din,
  output logic [ADDR_W-1:0] display_base,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              err_line,
  output logic              err_frame
);

  localparam logic [10:0] H_LIM  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM  = 10'(V_ACTIVE);
  localparam sdram_addr_t H_STEP = 25'(H_ACTIVE);

  logic             href;
  logic [PIX_W-1:0] data;
  logic             vsync_rise;
  logic             vsync_fall;
  logic             href_rise;
  logic             href_fall;

  camera_capture_sync_edge u_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .href       (href),
    .data       (data),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_rise  (href_rise),
    .href_fall  (href_fall)
  );

  state_t           state;
  state_t           state_n;
  logic [10:0]      x;
  logic [10:0]      x_n;
  logic [9:0]       y;
  logic [9:0]       y_n;
  sdram_addr_t      line_base;
  sdram_addr_t      line_base_n;
  logic             buf_sel;
  logic             buf_sel_n;
  sdram_addr_t      active_base;
  sdram_addr_t      display_base_n;
  logic [15:0]      frame_count_n;
  logic             frame_done_n;
  logic             err_line_n;
  logic             err_frame_n;
  logic             write_n;
  sdram_addr_t      addr_n;
  logic [PIX_W-1:0] din_n;
  logic [PIX_W-1:0] pixel;
  logic             take;
  logic             line_end;
  logic             frame_end;

  assign active_base = buf_sel ? (BUF0_BASE + BUF_STRIDE) : BUF0_BASE;

`ifdef CAMERA_CAPTURE_TEST_PATTERN_EN
  assign pixel = test_pattern ? pattern_pixel(x[4:0], y[4:0]) : data;
`else
  logic unused_test_pattern;
  assign unused_test_pattern = test_pattern;
  assign pixel = data;
`endif

  // Capture state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state, framing counters, write generation and frame-end bookkeeping.
  always_comb begin
    state_n        = state;
    x_n            = x;
    y_n            = y;
    line_base_n    = line_base;
    buf_sel_n      = buf_sel;
    display_base_n = display_base;
    frame_count_n  = frame_count;
    frame_done_n   = 1'b0;
    err_line_n     = err_line;
    err_frame_n    = err_frame;
    write_n        = 1'b0;
    addr_n         = portC_addr;
    din_n          = portC_din;
    take           = 1'b0;
    line_end       = 1'b0;
    frame_end      = 1'b0;

    case (state)
      IDLE: begin
        if (capture_en) begin
          state_n = SYNC;
        end else begin
          state_n = IDLE;
        end
      end
      SYNC: begin
        if (vsync_fall) begin
          x_n         = 11'd0;
          y_n         = 10'd0;
          line_base_n = active_base;
          state_n     = FRAME;
        end else begin
          state_n = SYNC;
        end
      end
      FRAME: begin
        if (vsync_rise) begin
          frame_end = 1'b1;
        end else if (href_rise) begin
          take    = 1'b1;
          state_n = LINE;
        end else begin
          state_n = FRAME;
        end
      end
      LINE: begin
        // A frame end during a line closes that line first.
        if (vsync_rise) begin
          line_end  = 1'b1;
          frame_end = 1'b1;
        end else if (href_fall) begin
          line_end = 1'b1;
          state_n  = FRAME;
        end else if (href) begin
          take = 1'b1;
        end else begin
          state_n = LINE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (take) begin
      if ((x < H_LIM) && (y < V_LIM)) begin
        write_n = 1'b1;
        addr_n  = line_base + {14'd0, x};
        din_n   = pixel;
        x_n     = x + 11'd1;
      end else begin
        err_line_n = 1'b1;
      end
    end else begin
      err_line_n = err_line_n;
    end

    // y and line_base stop at the last stored line so extra lines cannot wrap.
    if (line_end) begin
      x_n = 11'd0;
      if (y < V_LIM) begin
        y_n         = y + 10'd1;
        line_base_n = line_base + H_STEP;
      end else begin
        y_n = y;
      end
    end else begin
      y_n = y_n;
    end

    if (frame_end) begin
      if (y_n == V_LIM) begin
        frame_done_n   = 1'b1;
        frame_count_n  = frame_count + 16'd1;
        display_base_n = active_base;
        buf_sel_n      = ~buf_sel;
      end else begin
        err_frame_n = 1'b1;
      end
      if (capture_en) begin
        state_n = SYNC;
      end else begin
        state_n = IDLE;
      end
    end else begin
      frame_done_n = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x            <= 11'd0;
      y            <= 10'd0;
      line_base    <= 25'd0;
      buf_sel      <= 1'b0;
      display_base <= BUF0_BASE + BUF_STRIDE;
      frame_count  <= 16'd0;
      frame_done   <= 1'b0;
      err_line     <= 1'b0;
      err_frame    <= 1'b0;
      portC_write  <= 1'b0;
      portC_addr   <= 25'd0;
      portC_din    <= 10'd0;
    end else begin
      x            <= x_n;
      y            <= y_n;
      line_base    <= line_base_n;
      buf_sel      <= buf_sel_n;
      display_base <= display_base_n;
      frame_count  <= frame_count_n;
      frame_done   <= frame_done_n;
      err_line     <= err_line_n;
      err_frame    <= err_frame_n;
      portC_write  <= write_n;
      portC_addr   <= addr_n;
      portC_din    <= din_n;
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed, table-driven bench for camera_capture with a 4x3 active window.
module tb_camera_capture;

  logic        clk;
  logic        rst_n;
  logic        capture_en;
  logic        cam_vsync;
  logic        cam_href;
  logic [9:0]  cam_data;
  logic        test_pattern;
  logic        portC_write;
  logic [24:0] portC_addr;
  logic [9:0]  portC_din;
  logic [24:0] display_base;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        err_line;
  logic        err_frame;

  camera_capture #(
    .H_ACTIVE(4),
    .V_ACTIVE(3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture_en   (capture_en),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .cam_data     (cam_data),
    .test_pattern (test_pattern),
    .portC_write  (portC_write),
    .portC_addr   (portC_addr),
    .portC_din    (portC_din),
    .display_base (display_base),
    .frame_done   (frame_done),
    .frame_count  (frame_count),
    .err_line     (err_line),
    .err_frame    (err_frame)
  );

  typedef struct {
    int              nlines;
    logic [3:0][3:0] pix;
    int              seed;
    logic            cap_start;
    int              chg_line;
    logic            cap_chg;
    int              exp_writes;
    logic [24:0]     exp_base;
    int              exp_done;
    int              exp_count;
    logic [24:0]     exp_disp;
    logic            exp_el;
    logic            exp_ef;
  } vec_t;

  localparam int NV = 9;
  vec_t tbl [NV];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          first_pix_cyc;
  logic [34:0] wq [$];
  int          wc [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (portC_write === 1'b1) begin
      wq.push_back({portC_addr, portC_din});
      wc.push_back(cyc);
    end
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input vec_t v);
    capture_en = v.cap_start;
    cam_vsync  = 1'b1;
    cam_href   = 1'b0;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    first_pix_cyc = -1;
    for (int l = 0; l < v.nlines; l++) begin
      if (l == v.chg_line) capture_en = v.cap_chg;
      for (int p = 0; p < int'(v.pix[l]); p++) begin
        cam_href = 1'b1;
        cam_data = 10'(v.seed + l * 4 + p);
        if (first_pix_cyc < 0) first_pix_cyc = cyc;
        tick();
      end
      cam_href = 1'b0;
      cam_data = 10'd0;
      repeat (3) tick();
    end
    cam_vsync = 1'b1;
    repeat (6) tick();
  endtask

  initial begin
    int          d0;
    int          k;
    int          nl;
    int          np;
    logic [34:0] exp_w;
    logic [34:0] act_w;
    logic [9:0]  exp_tp;

    //           lines pix       seed cap  chg  new   wr  base        done cnt disp        el    ef
    tbl[0] = '{3, 16'h0444,   1, 1'b1, -1, 1'b1, 12, 25'd0,      1, 1, 25'd0,      1'b0, 1'b0};
    tbl[1] = '{3, 16'h0444, 101, 1'b1, -1, 1'b1, 12, 25'd524288, 1, 2, 25'd524288, 1'b0, 1'b0};
    tbl[2] = '{4, 16'h4446,  21, 1'b1, -1, 1'b1, 12, 25'd0,      1, 3, 25'd0,      1'b1, 1'b0};
    tbl[3] = '{2, 16'h0044,  41, 1'b1, -1, 1'b1,  8, 25'd524288, 0, 3, 25'd0,      1'b1, 1'b1};
    tbl[4] = '{3, 16'h0444,  61, 1'b1, -1, 1'b1, 12, 25'd524288, 1, 4, 25'd524288, 1'b1, 1'b1};
    tbl[5] = '{3, 16'h0444,  81, 1'b1,  1, 1'b0, 12, 25'd0,      1, 5, 25'd0,      1'b1, 1'b1};
    tbl[6] = '{3, 16'h0444, 121, 1'b0, -1, 1'b0,  0, 25'd0,      0, 5, 25'd0,      1'b1, 1'b1};
    tbl[7] = '{3, 16'h0444, 141, 1'b0,  1, 1'b1,  0, 25'd0,      0, 5, 25'd0,      1'b1, 1'b1};
    tbl[8] = '{3, 16'h0444, 161, 1'b1, -1, 1'b1, 12, 25'd524288, 1, 6, 25'd524288, 1'b1, 1'b1};

    rst_n        = 1'b0;
    capture_en   = 1'b0;
    cam_vsync    = 1'b1;
    cam_href     = 1'b0;
    cam_data     = 10'd0;
    test_pattern = 1'b0;
    tick();
    tick();
    check("rst_write",     64'(portC_write),  64'd0);
    check("rst_addr",      64'(portC_addr),   64'd0);
    check("rst_din",       64'(portC_din),    64'd0);
    check("rst_done",      64'(frame_done),   64'd0);
    check("rst_count",     64'(frame_count),  64'd0);
    check("rst_disp",      64'(display_base), 64'd524288);
    check("rst_err_line",  64'(err_line),     64'd0);
    check("rst_err_frame", 64'(err_frame),    64'd0);
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < NV; r++) begin
      wq.delete();
      wc.delete();
      d0 = done_cnt;
      send_frame(tbl[r]);
      check($sformatf("row%0d_nwrites", r), 64'(wq.size()), 64'(tbl[r].exp_writes));
      if (tbl[r].exp_writes > 0) begin
        k  = 0;
        nl = (tbl[r].nlines > 3) ? 3 : tbl[r].nlines;
        for (int l = 0; l < nl; l++) begin
          np = (int'(tbl[r].pix[l]) > 4) ? 4 : int'(tbl[r].pix[l]);
          for (int p = 0; p < np; p++) begin
            exp_w = {tbl[r].exp_base + 25'(l * 4 + p), 10'(tbl[r].seed + l * 4 + p)};
            act_w = (k < wq.size()) ? wq[k] : '1;
            check($sformatf("row%0d_write%0d", r, k), 64'(act_w), 64'(exp_w));
            k++;
          end
        end
        if (wc.size() > 0) check($sformatf("row%0d_latency", r), 64'(wc[0] - first_pix_cyc), 64'd2);
      end
      check($sformatf("row%0d_done_pulses", r), 64'(done_cnt - d0), 64'(tbl[r].exp_done));
      check($sformatf("row%0d_count", r),       64'(frame_count),   64'(tbl[r].exp_count));
      check($sformatf("row%0d_disp", r),        64'(display_base),  64'(tbl[r].exp_disp));
      check($sformatf("row%0d_err_line", r),    64'(err_line),      64'(tbl[r].exp_el));
      check($sformatf("row%0d_err_frame", r),   64'(err_frame),     64'(tbl[r].exp_ef));
    end

    // Reset in the middle of a line aborts the frame and clears all status.
    capture_en = 1'b1;
    cam_vsync  = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      cam_href = 1'b1;
      cam_data = 10'(500 + p);
      tick();
    end
    cam_href = 1'b0;
    repeat (3) tick();
    cam_href = 1'b1;
    cam_data = 10'd600;
    tick();
    cam_data = 10'd601;
    tick();
    cam_data = 10'd602;
    rst_n    = 1'b0;
    tick();
    check("midrst_write",     64'(portC_write),  64'd0);
    check("midrst_count",     64'(frame_count),  64'd0);
    check("midrst_disp",      64'(display_base), 64'd524288);
    check("midrst_err_line",  64'(err_line),     64'd0);
    check("midrst_err_frame", 64'(err_frame),    64'd0);
    rst_n = 1'b1;
    wq.delete();
    d0 = done_cnt;
    cam_data = 10'd603;
    tick();
    cam_href = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      cam_href = 1'b1;
      cam_data = 10'(700 + p);
      tick();
    end
    cam_href  = 1'b0;
    repeat (3) tick();
    cam_vsync = 1'b1;
    repeat (6) tick();
    check("postrst_nwrites", 64'(wq.size()),     64'd0);
    check("postrst_done",    64'(done_cnt - d0), 64'd0);

    // Pixel (x=2, y=1) of a frame captured with test_pattern held high.
    wq.delete();
    d0 = done_cnt;
    test_pattern = 1'b1;
    send_frame(tbl[0]);
    test_pattern = 1'b0;
`ifdef CAMERA_CAPTURE_TEST_PATTERN_EN
    exp_tp = 10'b00001_00010;
`else
    exp_tp = 10'd7;
`endif
    check("tp_nwrites", 64'(wq.size()), 64'd12);
    act_w = (wq.size() > 6) ? wq[6] : '1;
    check("tp_pixel_x2_y1", 64'(act_w), 64'({25'd6, exp_tp}));
    check("tp_done",  64'(done_cnt - d0), 64'd1);
    check("tp_count", 64'(frame_count),   64'd1);
    check("tp_disp",  64'(display_base),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
